// File: rtl/picocpu_pkg.sv
// Shared definitions for the picoCPU memory subsystem: bus widths and
// requester identities used by the memory arbiter.
package picocpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Per-requester wait counter: counts cycles spent requesting without a grant
// (saturating) and flags starvation once the limit is reached.
module arb_wait_timer
  import picocpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (req && !gnt) begin
      if (count != '1) count <= count + WAIT_W'(1);
    end else begin
      count <= '0;
    end
  end

  assign starved = req && (count >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU = M0, debug host = M1) in front of the single-port
// memory: round-robin or fixed priority, starvation override, M1 lock.
module mem_arbiter
  import picocpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic              M1_LOCK,
  output logic              M0_GNT,
  output logic              M1_GNT,
  output logic              M0_RVALID,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  req_id_t    last;
  logic       lock_own;
  logic [1:0] rd_owner;
  logic       starved0;
  logic       starved1;
  logic       gnt0;
  logic       gnt1;

  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
    .clk     (CLK),
    .rst     (RES),
    .req     (M0_REQ),
    .gnt     (gnt0),
    .starved (starved0)
  );

  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
    .clk     (CLK),
    .rst     (RES),
    .req     (M1_REQ),
    .gnt     (gnt1),
    .starved (starved1)
  );

  // Lock only binds while M1 keeps LOCK high; the release cycle arbitrates normally.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RES) begin
      if (lock_own && M1_LOCK) begin
        gnt1 = M1_REQ;
      end else if (starved0) begin
        gnt0 = 1'b1;
      end else if (starved1) begin
        gnt1 = 1'b1;
      end else if (M0_REQ && M1_REQ) begin
        if ((FIXED_PRI != 0) || (last == REQ_DBG)) gnt0 = 1'b1;
        else                                       gnt1 = 1'b1;
      end else begin
        gnt0 = M0_REQ;
        gnt1 = M1_REQ;
      end
    end
  end

  always_comb begin
    MEM_ADDR  = gnt1 ? M1_ADDR  : M0_ADDR;
    MEM_WDATA = gnt1 ? M1_WDATA : M0_WDATA;
    MEM_WE    = (gnt0 && M0_WE)  || (gnt1 && M1_WE);
    MEM_RE    = (gnt0 && !M0_WE) || (gnt1 && !M1_WE);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      last     <= REQ_DBG;
      lock_own <= 1'b0;
      rd_owner <= '0;
    end else begin
      if (gnt0)      last <= REQ_CPU;
      else if (gnt1) last <= REQ_DBG;
      lock_own <= M1_LOCK && (lock_own || gnt1);
      rd_owner <= {gnt1 && !M1_WE, gnt0 && !M0_WE};
    end
  end

  assign M0_GNT    = gnt0;
  assign M1_GNT    = gnt1;
  assign M0_RVALID = rd_owner[0];
  assign M1_RVALID = rd_owner[1];
  assign M0_RDATA  = MEM_RDATA;
  assign M1_RDATA  = MEM_RDATA;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, lock / reset / starvation
// sequences, and constrained-random traffic against a rule-level model.
module tb_mem_arbiter;
  import picocpu_pkg::*;

  localparam int MAX_WAIT_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: round-robin, with a behavioural memory behind it
  logic       a_res, a_m0_req, a_m0_we, a_m1_req, a_m1_we, a_m1_lock;
  logic [5:0] a_m0_addr, a_m1_addr, a_mem_addr;
  logic [7:0] a_m0_wdata, a_m1_wdata, a_mem_wdata, a_mem_rdata;
  logic       a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_re, a_mem_we;
  logic [7:0] a_m0_rdata, a_m1_rdata;

  // Instance B: fixed priority, constant read data
  logic       b_res, b_m0_req, b_m0_we, b_m1_req, b_m1_we, b_m1_lock;
  logic [5:0] b_m0_addr, b_m1_addr, b_mem_addr;
  logic [7:0] b_m0_wdata, b_m1_wdata, b_mem_wdata;
  logic [7:0] b_mem_rdata = 8'hc3;
  logic       b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_re, b_mem_we;
  logic [7:0] b_m0_rdata, b_m1_rdata;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT_A), .FIXED_PRI(0)) dut_a (
    .CLK(clk), .RES(a_res),
    .M0_REQ(a_m0_req), .M0_WE(a_m0_we), .M0_ADDR(a_m0_addr), .M0_WDATA(a_m0_wdata),
    .M1_REQ(a_m1_req), .M1_WE(a_m1_we), .M1_ADDR(a_m1_addr), .M1_WDATA(a_m1_wdata),
    .M1_LOCK(a_m1_lock),
    .M0_GNT(a_m0_gnt), .M1_GNT(a_m1_gnt),
    .M0_RVALID(a_m0_rvalid), .M1_RVALID(a_m1_rvalid),
    .M0_RDATA(a_m0_rdata), .M1_RDATA(a_m1_rdata),
    .MEM_ADDR(a_mem_addr), .MEM_RE(a_mem_re), .MEM_WE(a_mem_we),
    .MEM_WDATA(a_mem_wdata), .MEM_RDATA(a_mem_rdata)
  );

  mem_arbiter #(.MAX_WAIT(4), .FIXED_PRI(1)) dut_b (
    .CLK(clk), .RES(b_res),
    .M0_REQ(b_m0_req), .M0_WE(b_m0_we), .M0_ADDR(b_m0_addr), .M0_WDATA(b_m0_wdata),
    .M1_REQ(b_m1_req), .M1_WE(b_m1_we), .M1_ADDR(b_m1_addr), .M1_WDATA(b_m1_wdata),
    .M1_LOCK(b_m1_lock),
    .M0_GNT(b_m0_gnt), .M1_GNT(b_m1_gnt),
    .M0_RVALID(b_m0_rvalid), .M1_RVALID(b_m1_rvalid),
    .M0_RDATA(b_m0_rdata), .M1_RDATA(b_m1_rdata),
    .MEM_ADDR(b_mem_addr), .MEM_RE(b_mem_re), .MEM_WE(b_mem_we),
    .MEM_WDATA(b_mem_wdata), .MEM_RDATA(b_mem_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 33) ? 8'h0a : 8'(i * 3 + 1);
  endfunction

  // 64x8 memory with registered read; address 0x3f also drives PORTO
  logic [7:0] mem_a [64];
  logic [7:0] porto;
  bit         mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_val(i);
      porto     <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (a_mem_we) begin
        mem_a[a_mem_addr] <= a_mem_wdata;
        if (a_mem_addr == 6'h3f) porto <= a_mem_wdata;
      end
      if (a_mem_re) a_mem_rdata <= mem_a[a_mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of instance A, expressed directly as the arbitration rules
  int         m_last;
  bit         m_lock;
  int         m_wait [2];
  bit         m_rd   [2];
  int         m_g;
  logic [7:0] m_rdexp;
  logic [7:0] m_porto;
  logic [7:0] shadow [64];

  task automatic model_reset();
    m_last    = 1;
    m_lock    = 1'b0;
    m_wait[0] = 0;
    m_wait[1] = 0;
    m_rd[0]   = 1'b0;
    m_rd[1]   = 1'b0;
  endtask

  function automatic int pick();
    bit s0, s1;
    if (m_lock && a_m1_lock) return a_m1_req ? 1 : -1;
    s0 = a_m0_req && (m_wait[0] >= MAX_WAIT_A);
    s1 = a_m1_req && (m_wait[1] >= MAX_WAIT_A);
    if (s0) return 0;
    if (s1) return 1;
    if (a_m0_req && a_m1_req) return (m_last == 0) ? 1 : 0;
    if (a_m0_req) return 0;
    if (a_m1_req) return 1;
    return -1;
  endfunction

  // Called at the falling edge: compare, advance the model, move to next cycle.
  task automatic model_step();
    bit         we_g;
    logic [5:0] ad;
    logic [7:0] wd;
    if (a_res) model_reset();
    m_g  = a_res ? -1 : pick();
    we_g = (m_g == 1) ? a_m1_we    : a_m0_we;
    ad   = (m_g == 1) ? a_m1_addr  : a_m0_addr;
    wd   = (m_g == 1) ? a_m1_wdata : a_m0_wdata;
    check("model_gnt", {a_m1_gnt, a_m0_gnt}, {m_g == 1, m_g == 0});
    check("model_mem_en", {a_mem_re, a_mem_we}, {m_g >= 0 && !we_g, m_g >= 0 && we_g});
    check("model_mem_addr", a_mem_addr, ad);
    check("model_mem_wdata", a_mem_wdata, wd);
    check("model_rvalid", {a_m1_rvalid, a_m0_rvalid}, {m_rd[1], m_rd[0]});
    if (m_rd[0]) check("model_m0_rdata", a_m0_rdata, m_rdexp);
    if (m_rd[1]) check("model_m1_rdata", a_m1_rdata, m_rdexp);
    check("model_porto", porto, m_porto);
    if (!a_res) begin
      m_wait[0] = (a_m0_req && m_g != 0) ? ((m_wait[0] < 15) ? m_wait[0] + 1 : 15) : 0;
      m_wait[1] = (a_m1_req && m_g != 1) ? ((m_wait[1] < 15) ? m_wait[1] + 1 : 15) : 0;
      m_lock    = a_m1_lock && (m_lock || m_g == 1);
      if (m_g >= 0) m_last = m_g;
      m_rd[0] = (m_g == 0) && !we_g;
      m_rd[1] = (m_g == 1) && !we_g;
      if (m_g >= 0 && !we_g) m_rdexp = shadow[ad];
      if (m_g >= 0 && we_g) begin
        shadow[ad] = wd;
        if (ad == 6'h3f) m_porto = wd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit res, r0, we0, input logic [5:0] a0, input logic [7:0] d0,
                       input bit r1, we1, input logic [5:0] a1, input logic [7:0] d1,
                       input bit lk);
    a_res      = res;
    a_m0_req   = r0;  a_m0_we = we0; a_m0_addr = a0; a_m0_wdata = d0;
    a_m1_req   = r1;  a_m1_we = we1; a_m1_addr = a1; a_m1_wdata = d1;
    a_m1_lock  = lk;
  endtask

  typedef struct {
    bit         res;
    bit         r0;
    bit         we0;
    logic [5:0] a0;
    logic [7:0] d0;
    bit         r1;
    logic [5:0] a1;
    logic [1:0] gnt;    // {M1, M0}
    logic [1:0] en;     // {RE, WE}
    logic [5:0] addr;
    logic [1:0] rv;     // {M1, M0}
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit p0, p1;

    set_a(1, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0);
    b_res = 1'b1;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0; b_m1_lock = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    m_porto = 8'h00;
    m_rdexp = 8'h00;
    model_reset();

    //           res r0 we0 a0     d0     r1 a1     gnt    en     addr   rv     rdata
    tbl[0]  = '{1, 1, 0, 6'h05, 8'h00, 1, 6'h21, 2'b00, 2'b00, 6'h05, 2'b00, 8'h00};
    tbl[1]  = '{0, 1, 0, 6'h05, 8'h00, 1, 6'h21, 2'b01, 2'b10, 6'h05, 2'b00, 8'h00};
    tbl[2]  = '{0, 0, 0, 6'h05, 8'h00, 1, 6'h21, 2'b10, 2'b10, 6'h21, 2'b01, 8'h10};
    tbl[3]  = '{0, 0, 0, 6'h10, 8'h00, 0, 6'h21, 2'b00, 2'b00, 6'h10, 2'b10, 8'h0a};
    tbl[4]  = '{0, 1, 0, 6'h02, 8'h00, 1, 6'h03, 2'b01, 2'b10, 6'h02, 2'b00, 8'h00};
    tbl[5]  = '{0, 1, 0, 6'h04, 8'h00, 1, 6'h03, 2'b10, 2'b10, 6'h03, 2'b01, 8'h07};
    tbl[6]  = '{0, 1, 0, 6'h04, 8'h00, 1, 6'h06, 2'b01, 2'b10, 6'h04, 2'b10, 8'h0a};
    tbl[7]  = '{0, 1, 0, 6'h07, 8'h00, 1, 6'h06, 2'b10, 2'b10, 6'h06, 2'b01, 8'h0d};
    tbl[8]  = '{0, 1, 0, 6'h07, 8'h00, 1, 6'h08, 2'b01, 2'b10, 6'h07, 2'b10, 8'h13};
    tbl[9]  = '{0, 1, 0, 6'h09, 8'h00, 1, 6'h08, 2'b10, 2'b10, 6'h08, 2'b01, 8'h16};
    tbl[10] = '{0, 1, 1, 6'h0a, 8'h77, 0, 6'h08, 2'b01, 2'b01, 6'h0a, 2'b10, 8'h19};
    tbl[11] = '{0, 1, 0, 6'h0a, 8'h00, 0, 6'h08, 2'b01, 2'b10, 6'h0a, 2'b00, 8'h00};
    tbl[12] = '{0, 0, 0, 6'h00, 8'h00, 0, 6'h08, 2'b00, 2'b00, 6'h00, 2'b01, 8'h77};

    for (int i = 0; i < 13; i++) begin
      set_a(tbl[i].res, tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, 1'b0, tbl[i].a1, 8'h00, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), {a_m1_gnt, a_m0_gnt}, tbl[i].gnt);
      check($sformatf("vec%0d_en", i), {a_mem_re, a_mem_we}, tbl[i].en);
      check($sformatf("vec%0d_addr", i), a_mem_addr, tbl[i].addr);
      check($sformatf("vec%0d_rvalid", i), {a_m1_rvalid, a_m0_rvalid}, tbl[i].rv);
      if (tbl[i].rv[0]) check($sformatf("vec%0d_m0_rdata", i), a_m0_rdata, tbl[i].rdata);
      if (tbl[i].rv[1]) check($sformatf("vec%0d_m1_rdata", i), a_m1_rdata, tbl[i].rdata);
      model_step();
    end

    // Lock: M1 read-modify-write of 0x3f while M0 keeps asking
    set_a(0, 0, 0, 6'h01, 8'h00, 1, 0, 6'h3f, 8'h00, 1);
    @(negedge clk);
    check("lock_first_gnt", {a_m1_gnt, a_m0_gnt}, 2'b10);
    model_step();
    set_a(0, 1, 0, 6'h01, 8'h00, 1, 1, 6'h3f, 8'h01, 1);
    @(negedge clk);
    check("lock_write_gnt", {a_m1_gnt, a_m0_gnt}, 2'b10);
    check("lock_write_en", {a_mem_re, a_mem_we}, 2'b01);
    check("lock_read_rvalid", {a_m1_rvalid, a_m0_rvalid}, 2'b10);
    check("lock_read_rdata", a_m1_rdata, 8'hbe);
    model_step();
    for (int c = 0; c < 3; c++) begin
      set_a(0, 1, 0, 6'h01, 8'h00, 0, 0, 6'h3f, 8'h00, 1);
      @(negedge clk);
      check("lock_hold_gnt", {a_m1_gnt, a_m0_gnt}, 2'b00);
      if (c == 0) check("lock_porto", porto, 8'h01);
      model_step();
    end
    set_a(0, 1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 0);
    @(negedge clk);
    check("lock_release_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    model_step();
    set_a(0, 0, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 0);
    @(negedge clk);
    check("lock_after_gnt", {a_m1_gnt, a_m0_gnt}, 2'b10);
    model_step();

    // Reset right after a read grant cancels the response and restarts priority
    set_a(0, 1, 0, 6'h05, 8'h00, 1, 0, 6'h06, 8'h00, 0);
    @(negedge clk);
    check("rstmid_first_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    model_step();
    set_a(1, 1, 0, 6'h07, 8'h00, 1, 0, 6'h06, 8'h00, 0);
    @(negedge clk);
    check("rstmid_gnt", {a_m1_gnt, a_m0_gnt}, 2'b00);
    check("rstmid_en", {a_mem_re, a_mem_we}, 2'b00);
    check("rstmid_rvalid", {a_m1_rvalid, a_m0_rvalid}, 2'b00);
    model_step();
    set_a(0, 1, 0, 6'h07, 8'h00, 1, 0, 6'h06, 8'h00, 0);
    @(negedge clk);
    check("rstmid_restart_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    model_step();
    set_a(0, 0, 0, 6'h07, 8'h00, 1, 0, 6'h06, 8'h00, 0);
    @(negedge clk);
    check("rstmid_next_gnt", {a_m1_gnt, a_m0_gnt}, 2'b10);
    model_step();

    // Starvation on the fixed-priority instance: M1 forced in after 4 waits
    set_a(0, 0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0);
    for (int c = 0; c < 7; c++) begin
      b_res      = 1'b0;
      b_m0_req   = 1'b1; b_m0_we = 1'b0; b_m0_addr = 6'(16 + c); b_m0_wdata = 8'h4d;
      b_m1_req   = (c <= 4); b_m1_we = 1'b0; b_m1_addr = 6'h21; b_m1_wdata = 8'h99;
      @(negedge clk);
      check($sformatf("starve_c%0d_gnt", c), {b_m1_gnt, b_m0_gnt}, (c == 4) ? 2'b10 : 2'b01);
      check($sformatf("starve_c%0d_addr", c), b_mem_addr, (c == 4) ? 6'h21 : 6'(16 + c));
      check($sformatf("starve_c%0d_wdata", c), b_mem_wdata, (c == 4) ? 8'h99 : 8'h4d);
      check($sformatf("starve_c%0d_en", c), {b_mem_re, b_mem_we}, 2'b10);
      check($sformatf("starve_c%0d_rvalid", c), {b_m1_rvalid, b_m0_rvalid},
            (c == 0) ? 2'b00 : ((c == 5) ? 2'b10 : 2'b01));
      if (c == 5) check("starve_m1_rdata", b_m1_rdata, 8'hc3);
      if (c == 1) check("starve_m0_rdata", b_m0_rdata, 8'hc3);
      model_step();
    end
    b_m0_req = 1'b0;
    b_m1_req = 1'b0;

    // Random traffic: requests held until granted, lock toggling, rare resets
    p0 = 1'b0;
    p1 = 1'b0;
    a_m1_lock = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!p0) begin
        a_m0_req   = ($urandom_range(0, 99) < 60);
        a_m0_we    = 1'($urandom_range(0, 1));
        a_m0_addr  = 6'($urandom);
        a_m0_wdata = 8'($urandom);
      end
      if (!p1) begin
        a_m1_req   = ($urandom_range(0, 99) < 60);
        a_m1_we    = 1'($urandom_range(0, 1));
        a_m1_addr  = 6'($urandom);
        a_m1_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) a_m1_lock = ~a_m1_lock;
      a_res = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      model_step();
      p0 = a_m0_req && (m_g != 0);
      p1 = a_m1_req && (m_g != 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
